bsh_rr_arbiter: RTL
===================

Name: bsh_rr_arbiter

Overview:
- Shares one 8-bit logical-right barrel shifter (ba_shift: out = in >> ctrl, zero fill) between NREQ requesters.
- Each requester has a valid/ready request channel. One registered response channel carries the result and the requester ID.
- Grants are round-robin, with one-deep output buffering and full throughput under back-pressure-free operation.
- Sits between the instruction/bit-manipulation requesters and the shared shifter datapath.

Parameters:
- NREQ, 2, number of requesters; legal values 2..4.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  8*NREQ  operand; requester i uses bits [8i+7:8i].
- req_amt  in  3*NREQ  shift amount 0..7; requester i uses bits [3i+2:3i].
- req_ready  out  NREQ  per-requester accept; at most one bit set per cycle.
- rsp_valid  out  1  result register holds valid data.
- rsp_data  out  8  shifted result.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (async, while rst=1):
  - rsp_valid=0, rsp_data=8'h00, rsp_id=0.
  - Round-robin pointer rr_ptr=0, meaning requester 0 has highest priority.
  - req_ready=0 for all requesters while rst is high.
- Output slot:
  - can_accept = ~rsp_valid | rsp_ready.
  - The slot frees and refills in the same cycle, so sustained throughput is 1 result/clock.
- Arbitration (combinational each cycle):
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ. The first asserted index is the winner g.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - If no req_valid is asserted, all req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer on req_valid[g] & req_ready[g]:
  - On the next edge: rsp_data <= req_data[g] >> req_amt[g], computed through the instantiated shifter.
  - rsp_id <= g, rsp_valid <= 1, rr_ptr <= (g+1) mod NREQ.
  - Latency is 1 clock from the accepting edge to rsp_valid.
- Response-only consumption (rsp_valid & rsp_ready, no transfer that cycle): rsp_valid <= 0; rsp_data and rsp_id hold their last values.
- Stall (rsp_valid & ~rsp_ready):
  - rsp_valid, rsp_data and rsp_id hold stable.
  - rr_ptr holds.
  - No req_ready is asserted.
- rr_ptr advances only on an accepted transfer, never on idle or stall cycles.
- Fairness: a continuously requesting requester waits at most NREQ-1 accepted transfers.
- A requester may drop req_valid before it is granted; no state is retained for it.
- Shift amount 0 passes data through unchanged. Amount 7 yields {7'b0, data[7]}.
- Arithmetic is always a logical right shift with zero fill; there is no sign extension.
- Reset asserted mid-operation: a pending response is discarded (rsp_valid=0 immediately, asynchronously) and rr_ptr returns to 0.
- Reset release: arbitration resumes on the first rising edge after rst falls.

Test Plan:
1. Single request: NREQ=2, req0 data=8'hB4 amt=2 valid for 1 cycle, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=8'h2D, rsp_id=0; the following cycle rsp_valid=0.
2. Contention fairness: req0 and req1 both held valid (data 8'hFF, amt 1 and 3), rsp_ready=1 -> accepts alternate 0,1,0,1; rsp_data alternates 8'h7F, 8'h1F; one result per clock.
3. Back-pressure: rsp_ready=0 for 3 cycles with both valid -> rsp_valid stays 1 with rsp_data/rsp_id frozen, req_ready=0, rr_ptr unchanged. Raising rsp_ready accepts the next request in the same cycle.
4. Boundary amounts: amt=0 with 8'hA5 -> 8'hA5; amt=7 with 8'h80 -> 8'h01; amt=7 with 8'h7F -> 8'h00.
5. NREQ=4 wrap: only req3 and req0 valid, rr_ptr=3 -> grant 3, then 0, then 3. The pointer wraps 3->0 correctly.
6. Reset mid-stall: rsp_valid=1, rsp_ready=0, assert rst asynchronously -> rsp_valid=0, rsp_data=0 immediately. After release with req1 and req0 both valid, req0 is granted first.

Source files
------------

// File: rtl/bsh_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit logical-right barrel shifter.
// One registered response slot; refills in the same cycle it drains.

module ba_shift (
  input  logic [7:0] din,
  input  logic [2:0] ctrl,
  output logic [7:0] dout
);

  logic [7:0] s1;
  logic [7:0] s2;

  always_comb begin
    s1   = ctrl[0] ? {1'b0, din[7:1]} : din;
    s2   = ctrl[1] ? {2'b0, s1[7:2]}  : s1;
    dout = ctrl[2] ? {4'b0, s2[7:4]}  : s2;
  end

endmodule

module bsh_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [3*NREQ-1:0] req_amt,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  input  logic              rsp_ready
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] nxt_ptr;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;
  logic [ID_W-1:0] gnt_idx;
  logic            hi_found;
  logic            lo_found;
  logic            can_accept;
  logic            xfer;
  logic [7:0]      sel_data;
  logic [2:0]      sel_amt;
  logic [7:0]      shf_data;

  assign can_accept = ~rsp_valid | rsp_ready;

  // Rotating priority: first valid at or above rr_ptr, else lowest valid.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !hi_found &&
          ID_W'(i) >= rr_ptr) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
    end
  end

  assign gnt_idx = hi_found ? hi_idx : lo_idx;

  always_comb begin
    sel_data  = '0;
    sel_amt   = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_data     = req_data[8*i +: 8];
        sel_amt      = req_amt[3*i +: 3];
        req_ready[i] = ~rst & lo_found & can_accept;
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  assign nxt_ptr = (gnt_idx == ID_W'(NREQ-1)) ?
                   '0 : gnt_idx + ID_W'(1);

  ba_shift u_shift (
    .din  (sel_data),
    .ctrl (sel_amt),
    .dout (shf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= shf_data;
      rsp_id    <= gnt_idx;
      rr_ptr    <= nxt_ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
